score_controller: RTL and testbench

Game-level scoring controller for the Floppy Bird datapath. It runs the IDLE/PLAY/OVER game state machine, converts the bird's pipe-pass indication into single-cycle increment pulses for a chain of BCD digit counters, and freezes the score on collision. It also tracks the best score since reset and drives the seven-segment score digits. It sits between the game physics/collision logic and the HEX display outputs.

---
 rtl/score_pkg.sv | 60 ++++++
 rtl/bcd_digit.sv | 36 +++
 rtl/score_controller.sv | 144 ++++++++++++++
 tb/tb_score_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types, segment constants and BCD helpers for the Floppy Bird score path.
package score_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } game_state_t;

  // Widest score the compare helper accepts; callers zero-extend narrower scores.
  localparam int MAX_DIGITS = 8;
  localparam int BCD_MAX_W  = 4 * MAX_DIGITS;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Most significant differing digit decides; equal scores are not greater.
  function automatic logic bcd_gt(input logic [BCD_MAX_W-1:0] a,
                                  input logic [BCD_MAX_W-1:0] b);
    logic decided;
    logic gt;
    decided = 1'b0;
    gt      = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        decided = 1'b1;
        gt      = (a[4*i +: 4] > b[4*i +: 4]);
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the score chain; carry ripples combinationally to the next digit.
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    // NOTE: default assignment first so no path leaves digit_d unassigned (no latch).
    digit_d = digit_q;
    if (clear) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == 4'd9);

endmodule

// File: rtl/score_controller.sv
// Game FSM, saturating BCD score, best-score tracking and seven-segment drive.
module score_controller
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int OVER_HOLD  = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pass,
  input  logic                    collide,
  output logic                    playing,
  output logic                    game_over,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] best_bcd,
  output logic [7*NUM_DIGITS-1:0] hex_score,
  output logic                    new_best,
  output logic                    overflow
);

  localparam int SCORE_W = 4 * NUM_DIGITS;
  localparam int HOLD_W  = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVER_HOLD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {NUM_DIGITS{4'd9}};

  game_state_t         state_q;
  logic                start_q;
  logic                pass_q;
  logic                playing_q;
  logic                game_over_q;
  logic                new_best_q;
  logic                overflow_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [SCORE_W-1:0]  best_q;

  logic [SCORE_W-1:0]    score;
  logic [NUM_DIGITS-1:0] inc;
  logic [NUM_DIGITS-1:0] carry;

  logic start_edge;
  logic pass_edge;
  logic restart;
  logic saturated;
  logic score_inc;
  logic beats_best;

  assign start_edge = start & ~start_q;
  assign pass_edge  = pass & ~pass_q;
  assign saturated  = (score == SCORE_MAX);
  assign restart    = start_edge &
                      ((state_q == S_IDLE) || ((state_q == S_OVER) && (hold_q == '0)));
  assign score_inc  = (state_q == S_PLAY) & ~collide & pass_edge & ~saturated;
  assign beats_best = bcd_gt(BCD_MAX_W'(score), BCD_MAX_W'(best_q));

  assign inc[0] = score_inc;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_link
      assign inc[i] = carry[i-1];
    end
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clear (restart),
      .inc   (inc[i]),
      .digit (score[4*i +: 4]),
      .carry (carry[i])
    );
    assign hex_score[7*i +: 7] = bcd_to_seg(score[4*i +: 4]);
  end

  // Increments are gated at saturation, so the top digit can never carry out.
  a_no_wrap: assert property (@(posedge clk) disable iff (reset) !carry[NUM_DIGITS-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      // Edge history resets high so a button held through reset does not fire.
      start_q     <= 1'b1;
      pass_q      <= 1'b1;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      new_best_q  <= 1'b0;
      overflow_q  <= 1'b0;
      hold_q      <= '0;
      best_q      <= '0;
    end else begin
      start_q <= start;
      pass_q  <= pass;
      case (state_q)
        S_IDLE: begin
          if (restart) begin
            state_q     <= S_PLAY;
            playing_q   <= 1'b1;
            game_over_q <= 1'b0;
            new_best_q  <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        S_PLAY: begin
          if (collide) begin
            state_q     <= S_OVER;
            playing_q   <= 1'b0;
            game_over_q <= 1'b1;
            hold_q      <= HOLD_LOAD;
            if (beats_best) begin
              best_q     <= score;
              new_best_q <= 1'b1;
            end else begin
              new_best_q <= 1'b0;
            end
          end else if (pass_edge && saturated) begin
            overflow_q <= 1'b1;
          end
        end
        S_OVER: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
          end else if (restart) begin
            state_q     <= S_PLAY;
            playing_q   <= 1'b1;
            game_over_q <= 1'b0;
            new_best_q  <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          playing_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign score_bcd = score;
  assign best_bcd  = best_q;
  assign new_best  = new_best_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed scenarios plus randomized play checked against an integer-score game model.
module tb_score_controller;

  localparam int ND   = 3;
  localparam int OH   = 4;
  localparam int MAXS = 999;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pass = 1'b0;
  logic          collide = 1'b0;
  logic          playing;
  logic          game_over;
  logic [4*ND-1:0] score_bcd;
  logic [4*ND-1:0] best_bcd;
  logic [7*ND-1:0] hex_score;
  logic          new_best;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers and flags, advanced once per clock edge.
  int m_score = 0;
  int m_best  = 0;
  int m_hold  = 0;
  bit m_play  = 0;
  bit m_over  = 0;
  bit m_nb    = 0;
  bit m_ov    = 0;
  bit m_sprev = 1;
  bit m_pprev = 1;

  score_controller #(.NUM_DIGITS(ND), .OVER_HOLD(OH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pass      (pass),
    .collide   (collide),
    .playing   (playing),
    .game_over (game_over),
    .score_bcd (score_bcd),
    .best_bcd  (best_bcd),
    .hex_score (hex_score),
    .new_best  (new_best),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [20:0] to_hex(input int v);
    return {seg(v / 100 % 10), seg(v / 10 % 10), seg(v % 10)};
  endfunction

  task automatic model_step();
    bit se, pe;
    se = start && !m_sprev;
    pe = pass && !m_pprev;
    if (reset) begin
      m_score = 0; m_best = 0; m_hold = 0;
      m_play = 0; m_over = 0; m_nb = 0; m_ov = 0;
      m_sprev = 1; m_pprev = 1;
      return;
    end
    if (m_play) begin
      if (collide) begin
        m_play = 0; m_over = 1; m_hold = OH - 1;
        m_nb = (m_score > m_best);
        if (m_score > m_best) m_best = m_score;
      end else if (pe) begin
        if (m_score == MAXS) m_ov = 1;
        else m_score = m_score + 1;
      end
    end else if (m_over && m_hold != 0) begin
      m_hold = m_hold - 1;
    end else if (se) begin
      m_play = 1; m_over = 0; m_score = 0; m_nb = 0; m_ov = 0;
    end
    m_sprev = start;
    m_pprev = pass;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pass_pulse(input int hi);
    pass = 1'b1;
    repeat (hi) tick();
    pass = 1'b0;
    tick();
  endtask

  task automatic wait_hold_and_start();
    repeat (OH + 1) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if ({playing, game_over, new_best, overflow} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {playing, game_over, new_best, overflow});
    end
    total++;
    if (score_bcd !== 12'h000 || best_bcd !== 12'h000) begin
      bad++;
      $display("FAIL reset_scores: got score=%h best=%h want 000/000", score_bcd, best_bcd);
    end
    total++;
    if (hex_score !== to_hex(0)) begin
      bad++;
      $display("FAIL reset_hex: got %b want %b", hex_score, to_hex(0));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (playing !== 1'b0) begin
        bad++;
        $display("FAIL held_start_idle: cycle %0d got playing=%b want 0", i, playing);
      end
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    total++;
    if (playing !== 1'b1 || score_bcd !== 12'h000) begin
      bad++;
      $display("FAIL start_play: got playing=%b score=%h want 1/000", playing, score_bcd);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    repeat (3) pass_pulse(2);
    total++;
    if (score_bcd !== 12'h003) begin
      bad++;
      $display("FAIL pass_three: got %h want 003", score_bcd);
    end
    total++;
    if (hex_score[6:0] !== 7'b0110000) begin
      bad++;
      $display("FAIL hex_digit0: got %b want 0110000", hex_score[6:0]);
    end
    pass_pulse(10);
    total++;
    if (score_bcd !== 12'h004) begin
      bad++;
      $display("FAIL pass_level_once: got %h want 004", score_bcd);
    end
  endtask

  task automatic test_carry_saturate();
    repeat (95) pass_pulse(1);
    total++;
    if (score_bcd !== 12'h099) begin
      bad++;
      $display("FAIL preload_099: got %h want 099", score_bcd);
    end
    pass = 1'b1;
    tick();
    total++;
    if (score_bcd !== 12'h100 || hex_score !== to_hex(100)) begin
      bad++;
      $display("FAIL carry_100: got %h hex=%b want 100", score_bcd, hex_score);
    end
    pass = 1'b0;
    tick();
    repeat (899) pass_pulse(1);
    total++;
    if (score_bcd !== 12'h999 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reach_999: got %h ovf=%b want 999/0", score_bcd, overflow);
    end
    repeat (2) pass_pulse(1);
    total++;
    if (score_bcd !== 12'h999 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got %h ovf=%b want 999/1", score_bcd, overflow);
    end
    collide = 1'b1;
    tick();
    collide = 1'b0;
    total++;
    if (best_bcd !== 12'h999 || new_best !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL over_999: got best=%h nb=%b ovf=%b want 999/1/1", best_bcd, new_best, overflow);
    end
    wait_hold_and_start();
    total++;
    if (playing !== 1'b1 || score_bcd !== 12'h000 || overflow !== 1'b0 || best_bcd !== 12'h999) begin
      bad++;
      $display("FAIL restart_clears: got play=%b score=%h ovf=%b best=%h want 1/000/0/999",
               playing, score_bcd, overflow, best_bcd);
    end
  endtask

  task automatic test_collide_pass();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) pass_pulse(1);
    pass = 1'b1; collide = 1'b1;
    tick();
    total++;
    if (game_over !== 1'b1 || playing !== 1'b0 || score_bcd !== 12'h005 ||
        best_bcd !== 12'h005 || new_best !== 1'b1) begin
      bad++;
      $display("FAIL collide_wins: got go=%b play=%b score=%h best=%h nb=%b want 1/0/005/005/1",
               game_over, playing, score_bcd, best_bcd, new_best);
    end
    pass = 1'b0; collide = 1'b0;
    tick();
  endtask

  task automatic test_over_hold();
    start = 1'b1;
    tick();
    total++;
    if (playing !== 1'b0 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL hold_ignores_start: got play=%b go=%b want 0/1", playing, game_over);
    end
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    total++;
    if (playing !== 1'b1 || score_bcd !== 12'h000 || overflow !== 1'b0 ||
        best_bcd !== 12'h005 || new_best !== 1'b0) begin
      bad++;
      $display("FAIL hold_restart: got play=%b score=%h ovf=%b best=%h nb=%b want 1/000/0/005/0",
               playing, score_bcd, overflow, best_bcd, new_best);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_second_game();
    repeat (3) pass_pulse(1);
    collide = 1'b1;
    tick();
    collide = 1'b0;
    total++;
    if (game_over !== 1'b1 || score_bcd !== 12'h003 || best_bcd !== 12'h005 || new_best !== 1'b0) begin
      bad++;
      $display("FAIL no_new_best: got go=%b score=%h best=%h nb=%b want 1/003/005/0",
               game_over, score_bcd, best_bcd, new_best);
    end
  endtask

  task automatic test_mid_reset();
    wait_hold_and_start();
    repeat (42) pass_pulse(1);
    total++;
    if (score_bcd !== 12'h042 || playing !== 1'b1) begin
      bad++;
      $display("FAIL reach_042: got %h play=%b want 042/1", score_bcd, playing);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({playing, game_over, new_best, overflow} !== 4'b0000 || score_bcd !== 12'h000 ||
        best_bcd !== 12'h000 || hex_score !== to_hex(0)) begin
      bad++;
      $display("FAIL mid_reset: got flags=%b score=%h best=%h hex=%b want 0000/000/000/%b",
               {playing, game_over, new_best, overflow}, score_bcd, best_bcd, hex_score, to_hex(0));
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [48:0] got, want;
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 799) == 0);
      start   = ($urandom_range(0, 7) == 0);
      pass    = ($urandom_range(0, 2) == 0);
      collide = ($urandom_range(0, 39) == 0);
      tick();
      got  = {playing, game_over, new_best, overflow, score_bcd, best_bcd, hex_score};
      want = {m_play, m_over, m_nb, m_ov, to_bcd(m_score), to_bcd(m_best), to_hex(m_score)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL random_cycle_%0d: got %h want %h", n, got, want);
      end
    end
    reset = 1'b0; start = 1'b0; pass = 1'b0; collide = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_carry_saturate();
    test_collide_pass();
    test_over_hold();
    test_second_game();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
